bridge_rx_burst: RTL

Parametrised successor to the UART-side request parser. It turns an ASCII byte stream from `uart_rx` into read and write requests on the internal request bus, which feeds the core register chain. Compared with the fixed 16/16 parser it adds:
- configurable address and data widths;
- a burst-read command;
- true `req_ready` backpressure;
- error reporting that recovers on its own at the next end-of-line.

---
 rtl/bridge_pkg.sv | 40 ++++
 rtl/bridge_rx_burst.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bridge_pkg.sv
// Shared constants, FSM encoding and the ASCII hex decoder for the
// byte-stream request parser.
package bridge_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;
    localparam logic [1:0] S_ERROR   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_ACQUIRE = S_ACQUIRE,
        ST_ISSUE   = S_ISSUE,
        ST_ERROR   = S_ERROR
    } state_e;

    localparam logic [2:0] ERR_BADCHAR = 3'd1;
    localparam logic [2:0] ERR_BADLEN  = 3'd2;
    localparam logic [2:0] ERR_OVERRUN = 3'd3;
    localparam logic [2:0] ERR_ZEROLEN = 3'd4;

    localparam logic [7:0] ASCII_M    = 8'h4D;
    localparam logic [7:0] ASCII_M_LC = 8'h6D;
    localparam logic [7:0] ASCII_B    = 8'h42;
    localparam logic [7:0] ASCII_B_LC = 8'h62;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Returns {valid, nibble}; letters map via low nibble + 9 (A=0x41 -> 10).
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] result;
        result = 5'b0;
        if (c >= 8'h30 && c <= 8'h39)
            result = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            result = {1'b1, c[3:0] + 4'd9};
        return result;
    endfunction

endpackage

// File: rtl/bridge_rx_burst.sv
// ASCII command parser: turns M/B lines from uart_rx into read, write and
// burst-read requests with ready backpressure and self-recovering errors.
module bridge_rx_burst
    import bridge_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int BURST_DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            axiid,
    input  logic                  axiiv,
    output logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] req_data,
    output logic                  req_rw,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic                  err,
    output logic [2:0]            err_code
);

    localparam int ADDR_DIGITS  = ADDR_WIDTH / 4;
    localparam int DATA_DIGITS  = DATA_WIDTH / 4;
    localparam int TAIL_DIGITS  = (DATA_DIGITS > BURST_DIGITS) ? DATA_DIGITS : BURST_DIGITS;
    localparam int TOTAL_DIGITS = ADDR_DIGITS + TAIL_DIGITS;
    localparam int BUF_W        = TOTAL_DIGITS * 4;
    localparam int CNT_W        = $clog2(TOTAL_DIGITS + 1);
    localparam int BCNT_W       = BURST_DIGITS * 4;

    localparam logic [CNT_W-1:0] LEN_READ  = CNT_W'(ADDR_DIGITS);
    localparam logic [CNT_W-1:0] LEN_WRITE = CNT_W'(ADDR_DIGITS + DATA_DIGITS);
    localparam logic [CNT_W-1:0] LEN_BURST = CNT_W'(ADDR_DIGITS + BURST_DIGITS);

    state_e                  state_reg,    state_next;
    logic                    is_burst_reg, is_burst_next;
    logic [CNT_W-1:0]        cnt_reg,      cnt_next;
    logic [BUF_W-1:0]        buf_reg,      buf_next;
    logic [BCNT_W-1:0]       remain_reg,   remain_next;
    logic                    overrun_reg,  overrun_next;
    logic [ADDR_WIDTH-1:0]   req_addr_reg, req_addr_next;
    logic [DATA_WIDTH-1:0]   req_data_reg, req_data_next;
    logic                    req_rw_reg,   req_rw_next;
    logic                    req_valid_reg, req_valid_next;
    logic                    err_reg,      err_next;
    logic [2:0]              err_code_reg, err_code_next;

    logic [4:0]              hex;
    logic                    is_eol;
    logic                    is_cmd_m;
    logic                    is_cmd_b;
    logic [CNT_W-1:0]        max_len;
    logic [BCNT_W-1:0]       burst_cnt;

    assign hex       = hex_to_nibble(axiid);
    assign is_eol    = (axiid == ASCII_CR) || (axiid == ASCII_LF);
    assign is_cmd_m  = (axiid == ASCII_M) || (axiid == ASCII_M_LC);
    assign is_cmd_b  = (axiid == ASCII_B) || (axiid == ASCII_B_LC);
    assign max_len   = is_burst_reg ? LEN_BURST : LEN_WRITE;
    assign burst_cnt = buf_reg[BCNT_W-1:0];

    always_comb begin
        state_next     = state_reg;
        is_burst_next  = is_burst_reg;
        cnt_next       = cnt_reg;
        buf_next       = buf_reg;
        remain_next    = remain_reg;
        overrun_next   = overrun_reg;
        req_addr_next  = req_addr_reg;
        req_data_next  = req_data_reg;
        req_rw_next    = req_rw_reg;
        req_valid_next = req_valid_reg;
        err_next       = 1'b0;
        err_code_next  = err_code_reg;

        case (state_reg)
            ST_IDLE: begin
                if (axiiv) begin
                    if (is_cmd_m || is_cmd_b) begin
                        state_next    = ST_ACQUIRE;
                        is_burst_next = is_cmd_b;
                        cnt_next      = '0;
                        buf_next      = '0;
                    end else if (!is_eol) begin
                        state_next    = ST_ERROR;
                        err_next      = 1'b1;
                        err_code_next = ERR_BADCHAR;
                    end
                end
            end

            ST_ACQUIRE: begin
                if (axiiv) begin
                    if (hex[4]) begin
                        if (cnt_reg == max_len) begin
                            state_next    = ST_ERROR;
                            err_next      = 1'b1;
                            err_code_next = ERR_BADLEN;
                        end else begin
                            buf_next = {buf_reg[BUF_W-5:0], hex[3:0]};
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end else if (is_eol) begin
                        // Errors found on the EOL byte end the line, so go straight back to IDLE.
                        state_next = ST_IDLE;
                        if (!is_burst_reg && cnt_reg == LEN_READ) begin
                            state_next     = ST_ISSUE;
                            req_addr_next  = buf_reg[ADDR_WIDTH-1:0];
                            req_data_next  = '0;
                            req_rw_next    = 1'b0;
                            req_valid_next = 1'b1;
                            remain_next    = BCNT_W'(1);
                        end else if (!is_burst_reg && cnt_reg == LEN_WRITE) begin
                            state_next     = ST_ISSUE;
                            req_addr_next  = buf_reg[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
                            req_data_next  = buf_reg[DATA_WIDTH-1:0];
                            req_rw_next    = 1'b1;
                            req_valid_next = 1'b1;
                            remain_next    = BCNT_W'(1);
                        end else if (is_burst_reg && cnt_reg == LEN_BURST) begin
                            if (burst_cnt == '0) begin
                                err_next      = 1'b1;
                                err_code_next = ERR_ZEROLEN;
                            end else begin
                                state_next     = ST_ISSUE;
                                req_addr_next  = buf_reg[ADDR_WIDTH+BCNT_W-1 -: ADDR_WIDTH];
                                req_data_next  = '0;
                                req_rw_next    = 1'b0;
                                req_valid_next = 1'b1;
                                remain_next    = burst_cnt;
                            end
                        end else begin
                            err_next      = 1'b1;
                            err_code_next = ERR_BADLEN;
                        end
                    end else begin
                        state_next    = ST_ERROR;
                        err_next      = 1'b1;
                        err_code_next = ERR_BADCHAR;
                    end
                end
            end

            ST_ISSUE: begin
                if (axiiv) begin
                    err_next      = 1'b1;
                    err_code_next = ERR_OVERRUN;
                    overrun_next  = 1'b1;
                end
                if (req_ready) begin
                    if (remain_reg == BCNT_W'(1)) begin
                        req_valid_next = 1'b0;
                        overrun_next   = 1'b0;
                        state_next     = (overrun_reg || axiiv) ? ST_ERROR : ST_IDLE;
                    end else begin
                        req_addr_next = req_addr_reg + ADDR_WIDTH'(1);
                        remain_next   = remain_reg - BCNT_W'(1);
                    end
                end
            end

            ST_ERROR: begin
                if (axiiv && is_eol)
                    state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            is_burst_reg  <= 1'b0;
            cnt_reg       <= '0;
            buf_reg       <= '0;
            remain_reg    <= '0;
            overrun_reg   <= 1'b0;
            req_addr_reg  <= '0;
            req_data_reg  <= '0;
            req_rw_reg    <= 1'b0;
            req_valid_reg <= 1'b0;
            err_reg       <= 1'b0;
            err_code_reg  <= 3'd0;
        end else begin
            state_reg     <= state_next;
            is_burst_reg  <= is_burst_next;
            cnt_reg       <= cnt_next;
            buf_reg       <= buf_next;
            remain_reg    <= remain_next;
            overrun_reg   <= overrun_next;
            req_addr_reg  <= req_addr_next;
            req_data_reg  <= req_data_next;
            req_rw_reg    <= req_rw_next;
            req_valid_reg <= req_valid_next;
            err_reg       <= err_next;
            err_code_reg  <= err_code_next;
        end
    end

    assign req_addr  = req_addr_reg;
    assign req_data  = req_data_reg;
    assign req_rw    = req_rw_reg;
    assign req_valid = req_valid_reg;
    assign err       = err_reg;
    assign err_code  = err_code_reg;

endmodule
